// File: rtl/btn_debounce_if.sv
// Button bundle between the raw board buttons and the debounce block.
// The master drives the raw active-low buttons and the slave returns the conditioned state.
`timescale 1ns/1ps
interface btn_debounce_if #(
    parameter int N_BTN = 2
);
    logic [N_BTN-1:0] btn;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_busy;

    modport master (
        output btn,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_busy
    );

    modport slave (
        input  btn,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_busy
    );
endinterface

// File: rtl/btn_debounce.sv
// Per-button 2-FF synchronizer plus debounce FSM with registered level/press/release/busy outputs.
// Optional macro BTN_AUTOREPEAT_EN adds auto-repeat press pulses while a button stays held.
`timescale 1ns/1ps
module btn_debounce #(
    parameter int N_BTN         = 2,
    parameter int DB_CYCLES     = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic            clk1,
    input  logic            rst_n,
    btn_debounce_if.slave   bus
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef BTN_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DLY = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_PER = REP_W'(REPEAT_PERIOD);
`endif

    if (DB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("btn_debounce: DB_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    logic [N_BTN-1:0] sync1_reg;
    logic [N_BTN-1:0] sync2_reg;
    logic [N_BTN-1:0] level_reg,   level_next;
    logic [N_BTN-1:0] press_reg,   press_next;
    logic [N_BTN-1:0] release_reg, release_next;
    logic [N_BTN-1:0] busy_reg,    busy_next;

    // Synchronizer idles at 1 so a button held through reset is seen as a fresh press.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
        end else begin
            sync1_reg <= bus.btn;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi = gi + 1) begin : g_btn
            state_t           state_reg, state_next;
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic [CNT_W-1:0] cnt_inc;
            logic             s;
            logic             rep_fire;
            logic             lvl_n, prs_n, rel_n, bsy_n;

            assign s       = sync2_reg[gi];
            assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;

            always_ff @(posedge clk1 or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= RELEASED;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            // The sample that enters a WAIT state already counts as sample 1.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                case (state_reg)
                    RELEASED: begin
                        if (!s) begin
                            if (DB_CYCLES == 1) begin
                                state_next = PRESSED;
                                cnt_next   = '0;
                            end else begin
                                state_next = WAIT_PRESS;
                                cnt_next   = CNT_ONE;
                            end
                        end
                    end
                    WAIT_PRESS: begin
                        if (s) begin
                            state_next = RELEASED;
                            cnt_next   = '0;
                        end else if (cnt_inc == CNT_MAX) begin
                            state_next = PRESSED;
                            cnt_next   = '0;
                        end else begin
                            cnt_next   = cnt_inc;
                        end
                    end
                    PRESSED: begin
                        if (s) begin
                            if (DB_CYCLES == 1) begin
                                state_next = RELEASED;
                                cnt_next   = '0;
                            end else begin
                                state_next = WAIT_RELEASE;
                                cnt_next   = CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        if (!s) begin
                            state_next = PRESSED;
                            cnt_next   = '0;
                        end else if (cnt_inc == CNT_MAX) begin
                            state_next = RELEASED;
                            cnt_next   = '0;
                        end else begin
                            cnt_next   = cnt_inc;
                        end
                    end
                endcase
            end

`ifdef BTN_AUTOREPEAT_EN
            logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
            logic             rep_phase_reg, rep_phase_next;
            logic [REP_W-1:0] rep_inc;
            logic             rep_hold;

            assign rep_hold = (state_reg == PRESSED) && (state_next == PRESSED);
            assign rep_inc  = rep_cnt_reg + REP_W'(1);

            // First limit is the initial delay, every later one the repeat period.
            always_comb begin
                rep_cnt_next   = '0;
                rep_phase_next = 1'b0;
                rep_fire       = 1'b0;
                if (rep_hold) begin
                    if (rep_inc == (rep_phase_reg ? REP_PER : REP_DLY)) begin
                        rep_fire       = 1'b1;
                        rep_phase_next = 1'b1;
                    end else begin
                        rep_cnt_next   = rep_inc;
                        rep_phase_next = rep_phase_reg;
                    end
                end
            end

            always_ff @(posedge clk1 or negedge rst_n) begin
                if (!rst_n) begin
                    rep_cnt_reg   <= '0;
                    rep_phase_reg <= 1'b0;
                end else begin
                    rep_cnt_reg   <= rep_cnt_next;
                    rep_phase_reg <= rep_phase_next;
                end
            end
`else
            assign rep_fire = 1'b0;
`endif

            // Outputs are registered from the next state so they switch on the transition edge.
            always_comb begin
                lvl_n = (state_next == PRESSED) || (state_next == WAIT_RELEASE);
                bsy_n = (state_next == WAIT_PRESS) || (state_next == WAIT_RELEASE);
                prs_n = ((state_next == PRESSED) &&
                         ((state_reg == RELEASED) || (state_reg == WAIT_PRESS))) || rep_fire;
                rel_n = (state_next == RELEASED) &&
                        ((state_reg == PRESSED) || (state_reg == WAIT_RELEASE));
            end

            assign level_next[gi]   = lvl_n;
            assign press_next[gi]   = prs_n;
            assign release_next[gi] = rel_n;
            assign busy_next[gi]    = bsy_n;
        end
    endgenerate

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            level_reg   <= '0;
            press_reg   <= '0;
            release_reg <= '0;
            busy_reg    <= '0;
        end else begin
            level_reg   <= level_next;
            press_reg   <= press_next;
            release_reg <= release_next;
            busy_reg    <= busy_next;
        end
    end

    assign bus.btn_level   = level_reg;
    assign bus.btn_press   = press_reg;
    assign bus.btn_release = release_reg;
    assign bus.btn_busy    = busy_reg;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed self-checking bench for btn_debounce with DB_CYCLES=4 and two buttons.
// Auto-repeat expectations follow BTN_AUTOREPEAT_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_btn_debounce;
    localparam int N_BTN = 2;
    localparam int DB    = 4;
    localparam int RD    = 8;
    localparam int RP    = 3;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic clk1  = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    btn_debounce_if #(.N_BTN(N_BTN)) bus ();

    btn_debounce #(
        .N_BTN(N_BTN),
        .DB_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) u_dut (
        .clk1(clk1),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    endtask

    task automatic check_outs(input string tag, input logic [1:0] lvl, input logic [1:0] prs,
                              input logic [1:0] rel, input logic [1:0] bsy);
        check({tag, ".level"},   bus.btn_level,   lvl);
        check({tag, ".press"},   bus.btn_press,   prs);
        check({tag, ".release"}, bus.btn_release, rel);
        check({tag, ".busy"},    bus.btn_busy,    bsy);
    endtask

    // step(n) ends 1 ns after the n-th rising edge; a drive made before it is captured at the first.
    task automatic step(input int n);
        repeat (n) @(posedge clk1);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         bnc_low  [12];
        int         bnc_busy [12];
        logic [1:0] ep;
        logic [1:0] er;
        logic [1:0] el;

        bnc_low  = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        bnc_busy = '{0, 0, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0};

        // Scenario 1: both buttons held low through reset.
        bus.btn = 2'b00;
        rst_n   = 1'b0;
        #23;
        check_outs("rst_hold", 2'b00, 2'b00, 2'b00, 2'b00);
        step(2);
        check_outs("rst_hold2", 2'b00, 2'b00, 2'b00, 2'b00);
        rst_n = 1'b1;
        step(5);
        check_outs("rst_pre", 2'b00, 2'b00, 2'b00, 2'b11);
        step(1);
        check_outs("rst_accept", 2'b11, 2'b11, 2'b00, 2'b00);
        step(1);
        check_outs("rst_after", 2'b11, 2'b00, 2'b00, 2'b00);
        bus.btn = 2'b11;
        step(5);
        check_outs("rel2_pre", 2'b11, 2'b00, 2'b00, 2'b11);
        step(1);
        check_outs("rel2_accept", 2'b00, 2'b00, 2'b11, 2'b00);
        step(1);
        check_outs("rel2_after", 2'b00, 2'b00, 2'b00, 2'b00);
        $display("reset-with-held-buttons transaction done");

        // Scenario 2: clean press on button 0.
        bus.btn = 2'b10;
        step(5);
        check_outs("press_pre", 2'b00, 2'b00, 2'b00, 2'b01);
        step(1);
        check_outs("press_accept", 2'b01, 2'b01, 2'b00, 2'b00);
        step(1);
        check_outs("press_after", 2'b01, 2'b00, 2'b00, 2'b00);
        $display("clean press transaction done");

        // Scenario 4: release from PRESSED.
        bus.btn = 2'b11;
        step(5);
        check_outs("release_pre", 2'b01, 2'b00, 2'b00, 2'b01);
        step(1);
        check_outs("release_accept", 2'b00, 2'b00, 2'b01, 2'b00);
        step(1);
        check_outs("release_after", 2'b00, 2'b00, 2'b00, 2'b00);
        $display("release transaction done");

        // Scenario 3: bounce low3/high1/low2 never qualifies.
        for (int k = 0; k < 12; k++) begin
            bus.btn = (bnc_low[k] != 0) ? 2'b10 : 2'b11;
            step(1);
            check("bounce.level", bus.btn_level, 2'b00);
            check("bounce.press", bus.btn_press, 2'b00);
            check("bounce.busy",  bus.btn_busy,  (bnc_busy[k] != 0) ? 2'b01 : 2'b00);
        end
        $display("bounce transaction done");

        // Scenario 5: reset while WAIT_PRESS holds cnt=3.
        bus.btn = 2'b10;
        step(5);
        check_outs("midrst_wait", 2'b00, 2'b00, 2'b00, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("midrst_async", 2'b00, 2'b00, 2'b00, 2'b00);
        step(1);
        check_outs("midrst_held", 2'b00, 2'b00, 2'b00, 2'b00);
        rst_n = 1'b1;
        step(5);
        check_outs("midrst_pre", 2'b00, 2'b00, 2'b00, 2'b01);
        step(1);
        check_outs("midrst_accept", 2'b01, 2'b01, 2'b00, 2'b00);
        bus.btn = 2'b11;
        step(7);
        check_outs("midrst_released", 2'b00, 2'b00, 2'b00, 2'b00);
        $display("reset-mid-wait transaction done");

        // Scenario 6: long hold, auto-repeat pulses only with the feature built in.
        bus.btn = 2'b10;
        step(6);
        check("hold.first_press", bus.btn_press, 2'b01);
        check("hold.first_level", bus.btn_level, 2'b01);
        for (int k = 1; k < 20; k++) begin
            step(1);
            ep = (REP_ON && (k == 8 || k == 11 || k == 14 || k == 17)) ? 2'b01 : 2'b00;
            check("hold.press", bus.btn_press, ep);
        end
        bus.btn = 2'b11;
        for (int k = 20; k < 29; k++) begin
            step(1);
            ep = (REP_ON && k == 20) ? 2'b01 : 2'b00;
            er = (k == 25) ? 2'b01 : 2'b00;
            el = (k < 25) ? 2'b01 : 2'b00;
            check("unhold.press",   bus.btn_press,   ep);
            check("unhold.release", bus.btn_release, er);
            check("unhold.level",   bus.btn_level,   el);
        end
        $display("hold/auto-repeat transaction done (repeat %0d)", REP_ON);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
